// File: rtl/jump_redirect_ctrl.sv
// jump_redirect_ctrl: fetch-PC sequencer for the jump datapath.
// It holds the IF-stage PC. When EX resolves a JAL or JALR it redirects fetch
// to the target and flushes the wrong-path IF/ID and ID/EX registers. If the
// hazard unit is stalling when the jump arrives, the redirect waits until the
// stall is released.
// Optional build macro: MISALIGN_TRAP_EN. When it is defined, a target with
// target[1:0] != 0 loads TRAP_VECTOR instead, and misalign_trap pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// RUN     | normal sequential fetch, watching EX for a resolved jump
// PENDING | jump captured under stall; redirect fires once the stall releases
// SHADOW  | one cycle after a redirect; the EX slot is wrong-path, so ignore it

module jump_redirect_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
   parameter logic [5:0]  SEL_JAL     = 6'b000011,
   parameter logic [5:0]  SEL_JALR    = 6'b000100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic [5:0]  ex_aluSelect,
   input  logic [31:0] ex_target,
   output logic [31:0] pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        redirect,
   output logic        misalign_trap
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PENDING = 2'd1,
      ST_SHADOW  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pend_target;
   logic        jump_hit;
   logic        take;
   logic [31:0] load_target;
   logic [31:0] next_target;
   logic [31:0] pc_seq;

   // Decode the jump and pick the redirect target that will load at the next edge.
   always_comb begin
      jump_hit    = ex_valid & ((ex_aluSelect == SEL_JAL) | (ex_aluSelect == SEL_JALR));
      take        = ((state == ST_RUN) & jump_hit & ~stall) |
                    ((state == ST_PENDING) & ~stall);
      load_target = (state == ST_PENDING) ? pend_target : ex_target;
      pc_seq      = stall ? pc : (pc + 32'd4);
`ifdef MISALIGN_TRAP_EN
      misalign_trap = take & (load_target[1:0] != 2'b00);
      next_target   = misalign_trap ? TRAP_VECTOR : load_target;
`else
      misalign_trap = 1'b0;
      next_target   = load_target;
`endif
      redirect    = take;
      flush_if_id = take;
      flush_id_ex = take;
   end

   // Advance the sequencer state together with the PC and the pending target.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_RUN;
         pc          <= RESET_PC;
         pend_target <= 32'h0000_0000;
      end else begin
         case (state)
            ST_RUN: begin
               if (jump_hit && !stall) begin
                  pc    <= next_target;
                  state <= ST_SHADOW;
               end else if (jump_hit && stall) begin
                  pend_target <= ex_target;
                  state       <= ST_PENDING;
               end else begin
                  pc <= pc_seq;
               end
            end
            ST_PENDING: begin
               if (!stall) begin
                  pc    <= next_target;
                  state <= ST_SHADOW;
               end
            end
            ST_SHADOW: begin
               pc    <= pc_seq;
               state <= ST_RUN;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Bench for jump_redirect_ctrl. A cycle-level reference model is checked
// against the DUT on every falling edge, and directed literal checks pin the
// model to hand-computed values.
module tb_jump_redirect_ctrl;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        ex_valid;
   logic [5:0]  ex_aluSelect;
   logic [31:0] ex_target;
   logic [31:0] pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        redirect;
   logic        misalign_trap;

   int n_cmp  = 0;
   int n_fail = 0;

   jump_redirect_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stall        (stall),
      .ex_valid     (ex_valid),
      .ex_aluSelect (ex_aluSelect),
      .ex_target    (ex_target),
      .pc           (pc),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .redirect     (redirect),
      .misalign_trap(misalign_trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. It tracks the PC the fetch stream should hold, whether a
   // captured jump is still waiting, and whether this EX slot is wrong-path.
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_pend = '0;
   bit          m_wait = 0;
   bit          m_skip = 0;

   always @(negedge clk) begin
      bit          hit, go, trap;
      logic [31:0] tgt;
      if (!reset_n) begin
         m_pc = RESET_PC; m_pend = '0; m_wait = 0; m_skip = 0;
         chk("m_rst_pc", pc, RESET_PC);
         chk("m_rst_redirect", {31'd0, redirect}, 32'd0);
         chk("m_rst_trap", {31'd0, misalign_trap}, 32'd0);
      end else begin
         hit  = ex_valid && (ex_aluSelect == 6'b000011 || ex_aluSelect == 6'b000100);
         go   = 0;
         tgt  = ex_target;
         if (m_skip) go = 0;
         else if (m_wait) begin go = !stall; tgt = m_pend; end
         else go = hit && !stall;
         trap = TRAP_EN && go && (tgt[1:0] != 2'b00);
         if (trap) tgt = TRAP_VECTOR;
         chk("m_pc", pc, m_pc);
         chk("m_redirect", {31'd0, redirect}, {31'd0, go});
         chk("m_flush_if_id", {31'd0, flush_if_id}, {31'd0, go});
         chk("m_flush_id_ex", {31'd0, flush_id_ex}, {31'd0, go});
         chk("m_trap", {31'd0, misalign_trap}, {31'd0, trap});
         if (go) begin
            m_pc = tgt; m_skip = 1; m_wait = 0;
         end else if (m_skip) begin
            m_skip = 0;
            if (!stall) m_pc = m_pc + 32'd4;
         end else if (m_wait) begin
            // held until stall drops
         end else if (hit && stall) begin
            m_wait = 1; m_pend = ex_target;
         end else if (!stall) begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   task automatic drive(input logic v, input logic [5:0] sel, input logic [31:0] t, input logic st);
      ex_valid = v; ex_aluSelect = sel; ex_target = t; stall = st;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 6'd0, 32'd0, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      // run a little, then reset mid-run
      repeat (5) tick();
      chk("run_pc_14", pc, 32'h14);
      #1 reset_n = 1'b0;
      #1 chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_redirect", {31'd0, redirect}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick(); chk("rel_pc_4", pc, 32'h4);
      tick(); chk("rel_pc_8", pc, 32'h8);
      repeat (6) tick();
      chk("pc_20", pc, 32'h20);

      // JAL taken immediately
      drive(1, 6'b000011, 32'h78, 0);
      #1 chk("jal_redirect", {31'd0, redirect}, 32'd1);
      chk("jal_flush_if_id", {31'd0, flush_if_id}, 32'd1);
      chk("jal_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
      tick(); drive(0, 6'd0, 32'd0, 0);
      chk("jal_pc_78", pc, 32'h78);
      tick(); chk("jal_pc_7c", pc, 32'h7C);

      // JALR under stall, deferred
      drive(1, 6'b000100, 32'h12C, 1);
      #1 chk("stall_jalr_no_flush", {31'd0, flush_if_id}, 32'd0);
      tick(); drive(1, 6'b000011, 32'h999, 1);
      tick(); tick();
      chk("stall_pc_held", pc, 32'h7C);
      drive(0, 6'd0, 32'd0, 0);
      #1 chk("release_redirect", {31'd0, redirect}, 32'd1);
      tick(); chk("release_pc_12c", pc, 32'h12C);
      tick(); chk("release_pc_130", pc, 32'h130);

      // back-to-back jumps: second is in the shadow slot
      drive(1, 6'b000011, 32'h40, 0);
      tick(); drive(1, 6'b000100, 32'h80, 0);
      #1 chk("shadow_no_redirect", {31'd0, redirect}, 32'd0);
      tick(); drive(0, 6'd0, 32'd0, 0);
      chk("shadow_pc_44", pc, 32'h44);
      tick(); chk("shadow_pc_48", pc, 32'h48);

      // non-jumps
      drive(1, 6'b111111, 32'h200, 0);
      #1 chk("nonjump_sel", {31'd0, redirect}, 32'd0);
      tick(); chk("nonjump_pc_4c", pc, 32'h4C);
      drive(0, 6'b000011, 32'h200, 0);
      #1 chk("nonjump_invalid", {31'd0, redirect}, 32'd0);
      tick(); chk("nonjump_pc_50", pc, 32'h50);

      // stall without jump holds pc, no flush
      drive(0, 6'd0, 32'd0, 1);
      #1 chk("plain_stall_flush", {31'd0, flush_id_ex}, 32'd0);
      tick(); chk("plain_stall_pc", pc, 32'h50);

      // misaligned immediate target
      drive(1, 6'b000011, 32'h402, 0);
      #1 chk("mis_trap", {31'd0, misalign_trap}, {31'd0, TRAP_EN});
      tick(); drive(0, 6'd0, 32'd0, 0);
      chk("mis_pc", pc, TRAP_EN ? 32'h100 : 32'h402);
      #1 chk("mis_trap_pulse_end", {31'd0, misalign_trap}, 32'd0);
      tick();
      // misaligned pending target
      drive(1, 6'b000100, 32'h3FE, 1);
      tick(); drive(0, 6'd0, 32'd0, 0);
      #1 chk("mis_pend_trap", {31'd0, misalign_trap}, {31'd0, TRAP_EN});
      tick(); chk("mis_pend_pc", pc, TRAP_EN ? 32'h100 : 32'h3FE);
      tick();

      // wrap at top of address space
      drive(1, 6'b000011, 32'hFFFF_FFFC, 0);
      tick(); drive(0, 6'd0, 32'd0, 0);
      chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
      tick(); chk("wrap_pc_zero", pc, 32'h0);

      // reset while a redirect is pending drops it
      drive(1, 6'b000011, 32'h500, 1);
      tick();
      #1 reset_n = 1'b0;
      #1 chk("pend_rst_pc", pc, 32'h0);
      tick();
      reset_n = 1'b1;
      drive(0, 6'd0, 32'd0, 0);
      #1 chk("pend_rst_no_redirect", {31'd0, redirect}, 32'd0);
      tick(); chk("pend_rst_pc_4", pc, 32'h4);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
